pixel_fb_writer: RTL and testbench
==================================

Name: pixel_fb_writer

Overview:
Receiving end of the pixel-write stream (vga_x, vga_y, colour, plot, done) produced by the screen-draw blocks such as the background sweep.
- Buffers accepted pixels in a small FIFO.
- Range-checks and linearises coordinates into a 160x120 framebuffer address.
- Writes to a shared framebuffer RAM port that the scan-out side can stall.
- Reports end of frame once every buffered pixel has been committed.

Parameters:
WIDTH, 160, screen width in pixels
HEIGHT, 120, screen height in pixels
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
plot  in  1  pixel valid from producer
ready  out  1  block can accept a pixel this cycle
vga_x  in  8  pixel x
vga_y  in  7  pixel y
colour  in  3  pixel colour
done  in  1  end-of-frame marker from producer, single-cycle pulse
fb_busy  in  1  framebuffer port owned by scan-out; write not taken this cycle
fb_we  out  1  framebuffer write strobe
fb_addr  out  15  framebuffer address
fb_data  out  3  framebuffer write data
frame_done  out  1  one-cycle pulse: frame fully committed
pixel_count  out  15  pixels committed this frame
drop_count  out  8  out-of-range pixels dropped, saturating
fifo_empty  out  1  FIFO holds no entries

Behaviour:
- Reset values: ready=1, fb_we=0, fb_addr=0, fb_data=0, frame_done=0, pixel_count=0, drop_count=0, fifo_empty=1; FIFO and pending flags cleared.
- ready = (FIFO occupancy < DEPTH). It depends on occupancy only, not on a same-cycle pop.
- Accept condition: plot && ready.
- Range check: an accepted pixel with vga_x>=WIDTH or vga_y>=HEIGHT is dropped, not enqueued; drop_count+1, saturating at 255. x==WIDTH is the normal row-turn artefact and is silently dropped.
- In-range accept: enqueue {addr = vga_x + WIDTH*vga_y (15 bits; max 19199), colour}. Address is computed at enqueue.
- plot while ready=0: pixel is not taken; the producer must hold it.
- Write stage FSM:
  - W_IDLE: if FIFO non-empty, pop the head into the output register, go to W_WRITE.
  - W_WRITE: fb_we=1; addr/data held stable.
  - When fb_busy=0 the write completes that cycle and pixel_count increments. Then pop the next entry back-to-back if available (stay in W_WRITE); otherwise go to W_IDLE with fb_we=0 the following cycle.
  - When fb_busy=1, hold in W_WRITE.
- Total buffering is DEPTH+1 (FIFO plus output register).
- Latency: pixel accepted at cycle N with an empty pipe and fb_busy=0 gives fb_we=1 at N+1, committed at N+1.
- Frame FSM:
  - F_RUN: done=1 goes to F_DRAIN. done is sampled regardless of ready. If plot and done coincide, the pixel is processed first, subject to ready.
  - F_DRAIN: when the FIFO is empty and the write stage is in W_IDLE, go to F_PULSE. Further done pulses here are merged (ignored).
  - F_PULSE: frame_done=1 for one cycle, with pixel_count showing the final count. Next cycle pixel_count=0 and the state returns to F_RUN. drop_count is not cleared by frames, only by reset.
  - A pixel accepted during F_DRAIN/F_PULSE still enqueues; it delays F_PULSE and is counted in the current frame.
- Reset mid-operation: FIFO flushed, in-flight write abandoned, fb_we=0 from the cycle after reset is sampled, all counters zeroed.

Decomposition:
- Shared package: SCREEN_W=160, SCREEN_H=120, FB_ADDR_W=15, COLOUR_W=3, and the frame/write state encodings.
- One natural sub-module: pixel_fifo, a synchronous FIFO, DATA_W=18, DEPTH parameter, with push/pop/full/empty/count. A push when full and a pop when empty are ignored.

Test Plan:
1. Reset, fb_busy=0; plot x=5,y=2,colour=3'b101 for one cycle -> next cycle fb_we=1, fb_addr=325, fb_data=5; then pixel_count=1, fifo_empty=1.
2. plot x=160,y=0, then x=0,y=120 -> no fb_we ever, drop_count=2, pixel_count=0.
3. fb_busy=1, plot held high with 8 distinct pixels -> 5 accepted, then ready=0; fb_addr frozen on the first pixel. Release fb_busy -> 5 back-to-back writes in order, ready returns high, remaining pixels drain, pixel_count=8.
4. plot x=159,y=119 with done in the same cycle -> write addr 19199, then exactly one frame_done pulse the cycle after the write completes with pixel_count=1; pixel_count=0 the next cycle.
5. Full sweep: y=0..119, x=0..160 with plot=1, random fb_busy, done after the last row -> 19200 writes (address 0..19199 each exactly once), drop_count=120, exactly one frame_done with pixel_count=19200.
6. reset asserted for one cycle while 3 pixels are buffered and fb_busy=1 -> fb_we=0 next cycle, fifo_empty=1, pixel_count=0, drop_count=0, no frame_done; a subsequent single pixel behaves as in test 1.

Source files
------------

// File: rtl/pixel_fb_writer_pkg.sv
// Shared constants, state encodings and the framebuffer entry layout for the
// pixel framebuffer writer.
package pixel_fb_writer_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;
    localparam int COLOUR_W  = 3;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int ENTRY_W   = FB_ADDR_W + COLOUR_W;

    typedef enum logic {
        W_IDLE,
        W_WRITE
    } wr_state_e;

    typedef enum logic [1:0] {
        F_RUN,
        F_DRAIN,
        F_PULSE
    } frame_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOUR_W-1:0]  colour;
    } fb_entry_t;

    function automatic logic [FB_ADDR_W-1:0] lin_addr(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int unsigned    width
    );
        logic [31:0] a;
        a = 32'(x) + 32'(width) * 32'(y);
        return a[FB_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_fb_writer_if.sv
// Pixel-write stream from a screen-draw producer into the framebuffer writer.
interface pixel_fb_writer_if
    import pixel_fb_writer_pkg::*;
;
    logic                plot;
    logic                ready;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] colour;
    logic                done;

    modport master (
        output plot, vga_x, vga_y, colour, done,
        input  ready
    );

    modport slave (
        input  plot, vga_x, vga_y, colour, done,
        output ready
    );

endinterface

// File: rtl/pixel_fb_writer_fifo.sv
// Small synchronous FIFO with a combinational head; push when full and pop
// when empty are ignored.
module pixel_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// Buffers producer pixels, range-checks and linearises them, and commits them
// to a stallable framebuffer port, flagging end of frame once fully drained.
module pixel_fb_writer
    import pixel_fb_writer_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int DEPTH  = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    pixel_fb_writer_if.slave     pix,
    input  logic                 fb_busy_i,
    output logic                 fb_we_o,
    output logic [FB_ADDR_W-1:0] fb_addr_o,
    output logic [COLOUR_W-1:0]  fb_data_o,
    output logic                 frame_done_o,
    output logic [FB_ADDR_W-1:0] pixel_count_o,
    output logic [7:0]           drop_count_o,
    output logic                 fifo_empty_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    wr_state_e    w_state_q, w_state_d;
    frame_state_e f_state_q, f_state_d;

    fb_entry_t in_entry, head_entry, next_entry;
    fb_entry_t out_q, out_d;

    logic [FB_ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          accept, in_range, take, drop;
    logic          slot_free, bypass, fifo_push, fifo_pop, load_out, commit;

    assign pix.ready = (fifo_count < DEPTH_CNT);
    assign accept    = pix.plot && pix.ready;
    assign in_range  = ({24'd0, pix.vga_x} < 32'(WIDTH)) &&
                       ({25'd0, pix.vga_y} < 32'(HEIGHT));
    assign take      = accept && in_range;
    assign drop      = accept && !in_range;

    assign in_entry.addr   = lin_addr(pix.vga_x, pix.vga_y, WIDTH);
    assign in_entry.colour = pix.colour;

    // The output register can take a new entry when idle or when the current
    // write completes; with an empty FIFO the incoming pixel skips straight in.
    assign slot_free  = (w_state_q == W_IDLE) || !fb_busy_i;
    assign bypass     = take && fifo_empty && slot_free;
    assign fifo_push  = take && !bypass && !fifo_full;
    assign fifo_pop   = slot_free && !fifo_empty;
    assign load_out   = fifo_pop || bypass;
    assign next_entry = fifo_empty ? in_entry : head_entry;
    assign commit     = (w_state_q == W_WRITE) && !fb_busy_i;

    pixel_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (fifo_push),
        .data_i  (in_entry),
        .pop_i   (fifo_pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            w_state_q <= W_IDLE;
            f_state_q <= F_RUN;
        end else begin
            w_state_q <= w_state_d;
            f_state_q <= f_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (load_out) w_state_d = W_WRITE;
            W_WRITE: if (!fb_busy_i && !load_out) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Drain is judged on the write stage's next state so the pulse lands the
    // cycle after the last write completes.
    always_comb begin
        f_state_d = f_state_q;
        case (f_state_q)
            F_RUN:   if (pix.done) f_state_d = F_DRAIN;
            F_DRAIN: if (w_state_d == W_IDLE && fifo_empty) f_state_d = F_PULSE;
            F_PULSE: f_state_d = F_RUN;
            default: f_state_d = F_RUN;
        endcase
    end

    always_comb begin
        fb_we_o      = (w_state_q == W_WRITE);
        frame_done_o = (f_state_q == F_PULSE);
    end

    always_comb begin
        out_d      = load_out ? next_entry : out_q;
        pix_cnt_d  = pix_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (f_state_q == F_PULSE)
            pix_cnt_d = '0;
        else if (commit)
            pix_cnt_d = pix_cnt_q + FB_ADDR_W'(1);
        if (drop && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_q      <= '0;
            pix_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_q      <= out_d;
            pix_cnt_q  <= pix_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fb_addr_o     = out_q.addr;
    assign fb_data_o     = out_q.colour;
    assign pixel_count_o = pix_cnt_q;
    assign drop_count_o  = drop_cnt_q;
    assign fifo_empty_o  = fifo_empty;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Scoreboard bench for pixel_fb_writer: expected writes are queued on accept
// and compared in order as the framebuffer port commits them.
module tb_pixel_fb_writer;
    import pixel_fb_writer_pkg::*;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fb_busy;
    logic        fb_we, frame_done, fifo_empty;
    logic [14:0] fb_addr, pixel_count;
    logic [2:0]  fb_data;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    pixel_fb_writer_if pix();

    pixel_fb_writer dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .pix           (pix),
        .fb_busy_i     (fb_busy),
        .fb_we_o       (fb_we),
        .fb_addr_o     (fb_addr),
        .fb_data_o     (fb_data),
        .frame_done_o  (frame_done),
        .pixel_count_o (pixel_count),
        .drop_count_o  (drop_count),
        .fifo_empty_o  (fifo_empty)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   commits = 0, frames = 0, last_frame_count = 0;
    int   exp_count = 0, exp_drop = 0, dup_cnt = 0;
    bit   seen [19200];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            exp_count = 0;
            exp_drop  = 0;
        end else begin
            if (pix.plot && pix.ready) begin
                if (pix.vga_x < 8'd160 && pix.vga_y < 7'd120) begin
                    e.addr = 15'(int'(pix.vga_x) + 160 * int'(pix.vga_y));
                    e.c    = pix.colour;
                    sb_q.push_back(e);
                end else if (exp_drop < 255) begin
                    exp_drop++;
                end
            end
            if (fb_we && !fb_busy) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", fb_addr, e.addr);
                    check("wr_data", fb_data, e.c);
                end
                commits++;
                exp_count++;
                if (fb_addr < 15'd19200) begin
                    if (seen[fb_addr]) dup_cnt++;
                    seen[fb_addr] = 1'b1;
                end
            end
            if (frame_done) begin
                frames++;
                check("frame_pixel_count", pixel_count, exp_count);
                last_frame_count = pixel_count;
                exp_count = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int c, input bit rand_busy);
        bit acc;
        pix.plot   = 1'b1;
        pix.vga_x  = 8'(x);
        pix.vga_y  = 7'(y);
        pix.colour = 3'(c);
        for (int n = 0; n < 1000; n++) begin
            if (rand_busy) fb_busy = ($urandom_range(3) == 0);
            @(negedge clk);
            acc = pix.ready;
            tick();
            if (acc) begin
                pix.plot = 1'b0;
                return;
            end
        end
        check("send_timeout", 0, 1);
        pix.plot = 1'b0;
    endtask

    task automatic wait_frames(input int target, input bit rand_busy);
        for (int n = 0; n < 5000; n++) begin
            if (frames >= target) return;
            if (rand_busy) fb_busy = ($urandom_range(3) == 0);
            tick();
        end
        check("frame_timeout", frames, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rel, c0, f0, idx, nseen;
        bit   acc;

        rst        = 1'b1;
        fb_busy    = 1'b0;
        pix.plot   = 1'b0;
        pix.done   = 1'b0;
        pix.vga_x  = '0;
        pix.vga_y  = '0;
        pix.colour = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_ready", pix.ready, 1);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pixel_count", pixel_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_fifo_empty", fifo_empty, 1);

        // single pixel latency
        send(5, 2, 5, 0);
        check("t1_fb_we", fb_we, 1);
        check("t1_fb_addr", fb_addr, 325);
        check("t1_fb_data", fb_data, 5);
        tick();
        check("t1_pixel_count", pixel_count, 1);
        check("t1_fifo_empty", fifo_empty, 1);
        check("t1_we_low", fb_we, 0);

        // out-of-range drops and saturation
        do_reset();
        c0 = commits;
        send(160, 0, 1, 0);
        send(0, 120, 2, 0);
        repeat (3) tick();
        check("t2_drop_count", drop_count, 2);
        check("t2_pixel_count", pixel_count, 0);
        check("t2_no_writes", commits - c0, 0);
        for (int i = 0; i < 260; i++) send(200 + (i % 40), 127, 0, 0);
        tick();
        check("t2_drop_sat", drop_count, 255);
        check("t2_drop_model", drop_count, exp_drop);

        // backpressure: DEPTH+1 accepted, then back-to-back drain
        do_reset();
        fb_busy = 1'b1;
        idx = 0;
        rel = commits;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (idx < 8) begin
                pix.plot   = 1'b1;
                pix.vga_x  = 8'(10 + idx);
                pix.vga_y  = 7'(3 + idx);
                pix.colour = 3'(idx);
            end else begin
                pix.plot = 1'b0;
            end
            if (cyc == 8) begin
                check("t3_accepted", idx, 5);
                check("t3_ready_low", pix.ready, 0);
                check("t3_addr_frozen", fb_addr, 490);
                check("t3_we_held", fb_we, 1);
            end
            if (cyc == 10) begin
                fb_busy = 1'b0;
                rel = commits;
            end
            if (cyc == 15) check("t3_back_to_back", commits - rel, 5);
            @(negedge clk);
            acc = pix.plot && pix.ready;
            tick();
            if (acc) idx++;
        end
        check("t3_all_sent", idx, 8);
        check("t3_pixel_count", pixel_count, 8);
        check("t3_ready_back", pix.ready, 1);
        check("t3_fifo_empty", fifo_empty, 1);

        // corner pixel with coincident done
        do_reset();
        fb_busy    = 1'b0;
        f0         = frames;
        pix.plot   = 1'b1;
        pix.done   = 1'b1;
        pix.vga_x  = 8'd159;
        pix.vga_y  = 7'd119;
        pix.colour = 3'd6;
        tick();
        pix.plot = 1'b0;
        pix.done = 1'b0;
        check("t4_fb_we", fb_we, 1);
        check("t4_fb_addr", fb_addr, 19199);
        check("t4_no_early_done", frame_done, 0);
        tick();
        check("t4_frame_done", frame_done, 1);
        check("t4_final_count", pixel_count, 1);
        tick();
        check("t4_done_cleared", frame_done, 0);
        check("t4_count_cleared", pixel_count, 0);
        repeat (5) tick();
        check("t4_one_pulse", frames - f0, 1);

        // full sweep with random stalls
        do_reset();
        for (int i = 0; i < 19200; i++) seen[i] = 1'b0;
        dup_cnt = 0;
        c0 = commits;
        f0 = frames;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x <= 160; x++)
                send(x, y, (x + y) % 8, 1);
        pix.done = 1'b1;
        fb_busy  = ($urandom_range(3) == 0);
        tick();
        pix.done = 1'b0;
        wait_frames(f0 + 1, 1);
        fb_busy = 1'b0;
        repeat (5) tick();
        nseen = 0;
        for (int i = 0; i < 19200; i++) if (seen[i]) nseen++;
        check("t5_writes", commits - c0, 19200);
        check("t5_addr_cover", nseen, 19200);
        check("t5_dups", dup_cnt, 0);
        check("t5_drop_count", drop_count, 120);
        check("t5_frames", frames - f0, 1);
        check("t5_frame_count", last_frame_count, 19200);
        check("t5_sb_empty", sb_q.size(), 0);
        check("t5_count_cleared", pixel_count, 0);

        // reset while pixels are buffered behind a stalled port
        do_reset();
        fb_busy = 1'b1;
        send(200, 5, 1, 0);
        send(1, 1, 1, 0);
        send(2, 2, 2, 0);
        send(3, 3, 3, 0);
        check("t6_pre_drop", drop_count, 1);
        check("t6_pre_fifo", fifo_empty, 0);
        f0 = frames;
        c0 = commits;
        do_reset();
        check("t6_fb_we", fb_we, 0);
        check("t6_fifo_empty", fifo_empty, 1);
        check("t6_pixel_count", pixel_count, 0);
        check("t6_drop_count", drop_count, 0);
        fb_busy = 1'b0;
        repeat (3) tick();
        check("t6_no_writes", commits - c0, 0);
        check("t6_no_frame_done", frames - f0, 0);
        send(5, 2, 5, 0);
        check("t6_fb_we_after", fb_we, 1);
        check("t6_fb_addr_after", fb_addr, 325);
        check("t6_fb_data_after", fb_data, 5);
        tick();
        check("t6_pixel_count_after", pixel_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
